// File: rtl/ps2_pkg.sv
// Shared types and timing helpers for the PS/2 host transmitter and line filters.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    // Consecutive stable samples required before a filtered line changes.
    localparam int unsigned FILT_LEN = 8;

    function automatic int unsigned us_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned us);
        longint unsigned c;
        c = 64'(clk_freq) * 64'(us) / 64'd1000000;
        return c[31:0];
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus a FILT_LEN-cycle glitch filter for one PS/2 line.
module ps2_line_filter
    import ps2_pkg::*;
(
    input  logic clk_i,
    input  logic rst,
    input  logic line_i,
    output logic filt_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILT_LEN);

    logic [1:0]    sync_q;
    logic          filt_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // Lines idle high, so reset the filter to the released level.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            fall_q <= 1'b0;
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT_LEN - 1)) begin
                filt_q <= sync_q[1];
                fall_q <= ~sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign filt_o = filt_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: small command FIFO feeding the
// host-request serialiser on the shared open-drain clock/data pair.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50000000,
    parameter int unsigned INHIBIT_US   = 120,
    parameter int unsigned START_TMO_US = 15000,
    parameter int unsigned PKT_TMO_US   = 2000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst,
    input  logic [7:0]                  cmd_data,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        ps2_clk_i,
    input  logic                        ps2_data_i,
    output logic                        ps2_clk_oe,
    output logic                        ps2_data_oe,
    output logic                        busy,
    output logic                        done,
    output logic                        ack_ok,
    output logic                        tmo_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

    localparam int unsigned INH_CYC   = us_to_cycles(CLK_FREQ, INHIBIT_US);
    localparam int unsigned START_CYC = us_to_cycles(CLK_FREQ, START_TMO_US);
    localparam int unsigned PKT_CYC   = us_to_cycles(CLK_FREQ, PKT_TMO_US);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic clk_f, clk_fall, data_f, data_fall_unused;

    ps2_line_filter u_clk_filt  (.clk_i(clk_i), .rst(rst), .line_i(ps2_clk_i),
                                 .filt_o(clk_f), .fall_o(clk_fall));
    ps2_line_filter u_data_filt (.clk_i(clk_i), .rst(rst), .line_i(ps2_data_i),
                                 .filt_o(data_f), .fall_o(data_fall_unused));

    ps2_tx_state_t state_q, state_d;
    logic [31:0]   tmr_q, tmr_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [3:0]    clk_hi_q;
    logic [8:0]    frame_q;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          done_q, done_d, ack_ok_q, ack_ok_d, tmo_err_q, tmo_err_d;
    logic          ack_smp_q, ack_smp_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          push, pop, tmo;

    assign cmd_ready = (cnt_q != CW'(FIFO_DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state_q == IDLE) && (state_d == INHIBIT);
    assign tmo       = (state_q inside {RELEASE, SHIFT, ACK}) && !clk_fall && (tmr_q == '0);

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= cmd_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            bitcnt_q  <= '0;
            clk_hi_q  <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_ok_q  <= 1'b0;
            tmo_err_q <= 1'b0;
            ack_smp_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bitcnt_q  <= bitcnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            ack_ok_q  <= ack_ok_d;
            tmo_err_q <= tmo_err_d;
            ack_smp_q <= ack_smp_d;
            if (!clk_f) clk_hi_q <= '0;
            else if (clk_hi_q != 4'(FILT_LEN)) clk_hi_q <= clk_hi_q + 4'd1;
            if (pop) frame_q <= {~^mem_q[rd_ptr_q], mem_q[rd_ptr_q]};
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if ((cnt_q != '0) && (clk_hi_q == 4'(FILT_LEN))) state_d = INHIBIT;
            INHIBIT:   if (tmr_q == '0) state_d = RELEASE;
            RELEASE:   if (clk_fall) state_d = SHIFT; else if (tmo) state_d = IDLE;
            SHIFT:     if (clk_fall && bitcnt_q == 4'd9) state_d = ACK; else if (tmo) state_d = IDLE;
            ACK:       if (clk_fall) state_d = WAIT_IDLE; else if (tmo) state_d = IDLE;
            WAIT_IDLE: if (clk_f && data_f) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        tmr_d     = tmr_q;
        bitcnt_d  = bitcnt_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        ack_ok_d  = ack_ok_q;
        tmo_err_d = tmo_err_q;
        ack_smp_d = ack_smp_q;
        clk_oe_d  = (state_d == INHIBIT);
        if ((state_q inside {RELEASE, SHIFT, ACK}) && tmr_q != '0) tmr_d = tmr_q - 32'd1;
        case (state_q)
            IDLE: begin
                data_oe_d = 1'b0;
                if (state_d == INHIBIT) begin
                    tmr_d     = INH_CYC - 1;
                    data_oe_d = (INH_CYC == 1);
                end
            end
            // Start bit goes low during the final inhibit cycle, before clock release.
            INHIBIT: begin
                if (tmr_q != '0) begin
                    tmr_d     = tmr_q - 32'd1;
                    data_oe_d = (tmr_q == 32'd1);
                end else begin
                    tmr_d     = START_CYC - 1;
                    bitcnt_d  = '0;
                    data_oe_d = 1'b1;
                end
            end
            RELEASE: if (clk_fall) tmr_d = PKT_CYC - 1;
            SHIFT: begin
                if (clk_fall) begin
                    data_oe_d = (bitcnt_q < 4'd9) ? ~frame_q[bitcnt_q] : 1'b0;
                    bitcnt_d  = bitcnt_q + 4'd1;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ack_smp_d = ~data_f;
                    data_oe_d = 1'b0;
                end
            end
            WAIT_IDLE: begin
                data_oe_d = 1'b0;
                if (state_d == IDLE) begin
                    done_d    = 1'b1;
                    ack_ok_d  = ack_smp_q;
                    tmo_err_d = 1'b0;
                end
            end
            default: data_oe_d = 1'b0;
        endcase
        if (tmo) begin
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            ack_ok_d  = 1'b0;
            tmo_err_d = 1'b1;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign ack_ok      = ack_ok_q;
    assign tmo_err     = tmo_err_q;
    assign fifo_cnt    = cnt_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain PS/2 device model, byte-level scoreboard,
// table-driven frames, random frames and hand-written corner sequences.
module tb_ps2_host_tx;

    localparam int unsigned CLK_FREQ = 1000000;
    localparam int DEPTH    = 4;
    localparam int INH_EXP  = 120;    // 120 us at 1 MHz
    localparam int TMO_EXP  = 15000;  // 15 ms at 1 MHz
    localparam int H        = 20;     // device half clock period, cycles

    logic       clk, rst;
    logic [7:0] cmd_data;
    logic       cmd_valid, cmd_ready;
    logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
    logic       busy, done, ack_ok, tmo_err;
    logic [2:0] fifo_cnt;
    logic       dev_clk, dev_data;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [1:0] done_q[$];

    ps2_host_tx #(.CLK_FREQ(CLK_FREQ), .INHIBIT_US(120), .START_TMO_US(15000),
                  .PKT_TMO_US(2000), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
        .done(done), .ack_ok(ack_ok), .tmo_err(tmo_err), .fifo_cnt(fifo_cnt));

    // Open-drain wired-AND of host and device.
    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_q.push_back({ack_ok, tmo_err});

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         exp_par;
        bit         exp_ack_ok;
        bit         exp_tmo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit odd_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        exp_q.push_back(b);
    endtask

    task automatic wait_oe(input logic lvl, input int lim, output bit ok);
        int n = 0;
        while (ps2_clk_oe !== lvl && n < lim) begin @(negedge clk); n++; end
        ok = (ps2_clk_oe === lvl);
    endtask

    // Device side of one host-request frame; bits[i] sampled at rising edge i.
    task automatic dev_frame(input bit do_ack, output logic [10:0] bits,
                             output int inh_len, output bit start_lo, output bit ok);
        bits = '1; inh_len = 0; start_lo = 1'b0;
        wait_oe(1'b1, 400, ok);
        if (!ok) return;
        while (ps2_clk_oe === 1'b1 && inh_len < 1000) begin
            start_lo = ps2_data_oe;
            @(negedge clk);
            inh_len++;
        end
        if (ps2_clk_oe === 1'b1) begin ok = 1'b0; return; end
        repeat (H) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            bits[i] = ps2_data_i;
            if (i == 10 && do_ack) dev_data = 1'b0;
            repeat (H) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic expect_done(input bit e_ack, input bit e_tmo, input string tag);
        int n = 0;
        logic [1:0] r;
        while (done_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
        if (done_q.size() == 0) begin
            check({tag, "_done_seen"}, 0, 1);
        end else begin
            r = done_q.pop_front();
            check({tag, "_ack_ok"}, r[1], e_ack);
            check({tag, "_tmo_err"}, r[0], e_tmo);
        end
    endtask

    task automatic run_frame(input bit do_ack, input bit exp_par, input bit chk_inh, input string tag);
        logic [10:0] bits;
        int inh;
        bit st, ok;
        logic [7:0] b;
        if (exp_q.size() == 0) begin check({tag, "_model_empty"}, 1, 0); return; end
        b = exp_q.pop_front();
        dev_frame(do_ack, bits, inh, st, ok);
        check({tag, "_frame_ok"}, ok, 1);
        if (!ok) return;
        if (chk_inh) begin
            check({tag, "_inhibit_len"}, inh, INH_EXP);
            check({tag, "_start_before_release"}, st, 1);
        end
        check({tag, "_start"}, bits[0], 0);
        check({tag, "_data"}, bits[8:1], b);
        check({tag, "_parity"}, bits[9], exp_par);
        check({tag, "_stop"}, bits[10], 1);
        expect_done(do_ack, 1'b0, tag);
    endtask

    initial begin
        vec_t vecs[5];
        bit ok, exp_rdy;
        int n, mcnt;
        logic [7:0] rb;
        bit rack;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hF4, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_ok", ack_ok, 0);
        check("rst_tmo_err", tmo_err, 0);
        check("rst_fifo_cnt", fifo_cnt, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        repeat (20) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            push(vecs[i].data);
            run_frame(vecs[i].ack, vecs[i].exp_par, 1'b1, $sformatf("vec%0d", i));
            if (i == 0) check("vec0_ack_hold", ack_ok, 1);
        end

        for (int i = 0; i < 6; i++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = 1'($urandom_range(0, 1));
            push(rb);
            run_frame(rack, odd_par(rb), 1'b1, $sformatf("rnd%0d", i));
        end

        // Device never clocks: first byte times out, second goes out normally.
        push(8'hA5);
        push(8'h3C);
        wait_oe(1'b1, 400, ok);
        check("tmo_inhibit_seen", ok, 1);
        wait_oe(1'b0, 1000, ok);
        check("tmo_release_seen", ok, 1);
        n = 0;
        while (done !== 1'b1 && n < TMO_EXP + 1000) begin @(negedge clk); n++; end
        check("tmo_done_window", (n >= TMO_EXP - 2 && n <= TMO_EXP + 2), 1);
        check("tmo_clk_oe_off", ps2_clk_oe, 0);
        check("tmo_data_oe_off", ps2_data_oe, 0);
        check("tmo_flag", tmo_err, 1);
        check("tmo_ack_ok", ack_ok, 0);
        void'(exp_q.pop_front());
        expect_done(1'b0, 1'b1, "tmo");
        run_frame(1'b1, odd_par(8'h3C), 1'b0, "after_tmo");

        // Device holds clock low so nothing is popped; fill the FIFO.
        repeat (30) @(negedge clk);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        mcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_rdy = (mcnt < DEPTH);
            check($sformatf("fifo_ready%0d", i), cmd_ready, exp_rdy);
            cmd_valid = 1'b1;
            cmd_data  = 8'(8'h10 + i);
            if (exp_rdy) begin exp_q.push_back(cmd_data); mcnt++; end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("fifo_full_cnt", fifo_cnt, DEPTH);
        check("fifo_full_ready", cmd_ready, 0);
        dev_clk = 1'b1;
        for (int i = 0; i < DEPTH; i++) run_frame(1'b1, odd_par(exp_q[0]), 1'b0, $sformatf("fifo%0d", i));

        // Reset in SHIFT after the fifth falling edge (bitcnt=4).
        repeat (30) @(negedge clk);
        push(8'h81);
        push(8'h42);
        wait_oe(1'b1, 400, ok);
        check("mid_inhibit_seen", ok, 1);
        wait_oe(1'b0, 1000, ok);
        check("mid_release_seen", ok, 1);
        repeat (H) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            if (k < 4) begin dev_clk = 1'b1; repeat (H) @(negedge clk); end
        end
        check("mid_busy", busy, 1);
        check("mid_fifo_cnt", fifo_cnt, 1);
        check("mid_data_d3", ps2_data_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_clk_oe", ps2_clk_oe, 0);
        check("mid_rst_data_oe", ps2_data_oe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_fifo_cnt", fifo_cnt, 0);
        check("mid_rst_ready", cmd_ready, 1);
        rst = 1'b0;
        dev_clk = 1'b1;
        exp_q.delete();
        done_q.delete();
        repeat (20) @(negedge clk);
        push(8'hFF);
        run_frame(1'b1, 1'b1, 1'b1, "post_rst_ff");

        repeat (20) @(negedge clk);
        check("final_idle", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
